// File: rtl/nand_rr_scheduler.sv
// Round-robin scheduler feeding a shared, fixed-latency bitwise NAND pipeline.
// Results come back tagged with the requester ID and are counted in a saturating counter.

module nand_rr_stage #(
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_vld,
  input  logic [IDW-1:0] in_id,
  input  logic [W-1:0]   in_data,
  output logic           vld,
  output logic [IDW-1:0] id,
  output logic [W-1:0]   data
);
  // id/data only move with a valid op so the last stage holds its last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      id   <= '0;
      data <= '0;
    end else begin
      vld <= in_vld;
      if (in_vld) begin
        id   <= in_id;
        data <= in_data;
      end
    end
  end
endmodule

module nand_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int W       = 8,
  parameter int LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*W-1:0] op_a,
  input  logic [NUM_REQ*W-1:0] op_b,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [W-1:0]         rsp_data,
  output logic                 busy,
  output logic [7:0]           op_count
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [IDW:0]   NR   = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ-1);

  logic [IDW-1:0] ptr, gidx;
  logic           found;
  logic [NUM_REQ-1:0] rot;
  logic [IDW:0]   sum;

  logic [LATENCY:0]          vld_pipe;
  logic [LATENCY:0][IDW-1:0] id_pipe;
  logic [LATENCY:0][W-1:0]   dat_pipe;

  // rot[k] is req of requester (ptr+k) mod NUM_REQ; lowest set k wins
  always_comb begin
    rot   = NUM_REQ'({req, req} >> ptr);
    gnt   = '0;
    gidx  = '0;
    found = 1'b0;
    sum   = '0;
    if (ena && rst_n) begin
      for (int k = NUM_REQ-1; k >= 0; k--) begin
        if (rot[k]) begin
          found = 1'b1;
          sum   = {1'b0, ptr} + (IDW+1)'(k);
        end
      end
      if (sum >= NR) sum = sum - NR;
      gidx = sum[IDW-1:0];
      if (found) gnt[gidx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= '0;
    else if (found) ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
  end

  assign vld_pipe[0] = found;
  assign id_pipe[0]  = gidx;
  assign dat_pipe[0] = ~(op_a[gidx*W +: W] & op_b[gidx*W +: W]);

  for (genvar s = 1; s <= LATENCY; s++) begin : g_stage
    nand_rr_stage #(.W(W), .IDW(IDW)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (vld_pipe[s-1]),
      .in_id   (id_pipe[s-1]),
      .in_data (dat_pipe[s-1]),
      .vld     (vld_pipe[s]),
      .id      (id_pipe[s]),
      .data    (dat_pipe[s])
    );
  end

  assign rsp_valid = vld_pipe[LATENCY];
  assign rsp_id    = 3'(id_pipe[LATENCY]);
  assign rsp_data  = dat_pipe[LATENCY];
  assign busy      = |vld_pipe[LATENCY:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           op_count <= '0;
    else if (rsp_valid && op_count != 8'hFF) op_count <= op_count + 8'd1;
  end
endmodule

// File: tb/tb_nand_rr_scheduler.sv
// Randomized scoreboard bench: a round-robin reference pushes expected results,
// an independent monitor pops and compares them against the response port.

module tb_nand_rr_scheduler;
  localparam int N = 4, W = 8, L = 2;

  logic clk = 1'b0, rst_n = 1'b1, ena = 1'b0;
  logic [N-1:0]   req  = '0;
  logic [N*W-1:0] op_a = '0, op_b = '0;
  logic [N-1:0]   gnt;
  logic           rsp_valid, busy;
  logic [2:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic [7:0]     op_count;

  nand_rr_scheduler #(.NUM_REQ(N), .W(W), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic [2:0] id; logic [W-1:0] data; } exp_t;
  exp_t q[$];
  int ptr_m = 0, cnt_m = 0, checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Reference arbiter: scan from the pointer, first requester with req set wins
  always @(negedge clk) begin : ref_model
    int gi;
    logic [N-1:0] eg;
    gi = -1;
    eg = '0;
    if (rst_n && ena)
      for (int k = 0; k < N; k++)
        if (gi < 0 && req[(ptr_m + k) % N]) gi = (ptr_m + k) % N;
    if (gi >= 0) eg[gi] = 1'b1;
    chk(rst_n ? "gnt" : "gnt_in_reset", 32'(gnt), 32'(eg));
    if (gi >= 0) begin
      q.push_back('{cyc + L, 3'(gi), ~(op_a[gi*W +: W] & op_b[gi*W +: W])});
      ptr_m = (gi + 1) % N;
    end
  end

  always @(negedge clk) begin : monitor
    logic ev, eb;
    if (rst_n) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL lost_rsp id %0d due cycle %0d never returned", q[0].id, q[0].due);
        void'(q.pop_front());
      end
      ev = (q.size() > 0) && (q[0].due == cyc);
      eb = 1'b0;
      foreach (q[j]) if (q[j].due - L < cyc) eb = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(eb));
      chk("op_count", 32'(op_count), 32'(cnt_m));
      if (ev) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_data", 32'(rsp_data), 32'(q[0].data));
        void'(q.pop_front());
        if (cnt_m < 255) cnt_m++;
      end
    end
  end

  task automatic step(input logic e, input logic [N-1:0] r);
    @(posedge clk); #1;
    ena = e;
    req = r;
    op_a = {$urandom};
    op_b = {$urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 ena = 1'b1; req = '1;
    #1;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_op_count", 32'(op_count), 0);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    @(posedge clk); #1 req = '0; rst_n = 1'b1;

    // single op: 0xF0 nand 0xCC = 0x3F
    step(1'b1, 4'b0001);
    op_a[7:0] = 8'hF0; op_b[7:0] = 8'hCC;
    idle(4);

    // fairness: all requesting, operands equal to index
    for (int c = 0; c < 8; c++) begin
      step(1'b1, '1);
      for (int i = 0; i < N; i++) begin
        op_a[i*W +: W] = W'(i);
        op_b[i*W +: W] = W'(i);
      end
    end
    idle(3);

    // pointer skip after a grant to requester 1
    step(1'b1, 4'b0010);
    step(1'b1, 4'b0011);
    step(1'b1, 4'b0011);
    idle(3);

    for (int c = 0; c < 300; c++) step($urandom_range(0, 7) != 0, N'($urandom));
    idle(4);

    // ena gating with requests pending
    step(1'b1, '1);
    step(1'b1, '1);
    for (int c = 0; c < 5; c++) step(1'b0, '1);
    idle(2);

    // reset while an op is in flight
    step(1'b1, 4'b0001);
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_op_count", 32'(op_count), 0);
    q.delete();
    ptr_m = 0;
    cnt_m = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    idle(3);
    step(1'b1, '1);
    idle(4);

    // saturation of the completed-op counter
    for (int c = 0; c < 262; c++) step(1'b1, 4'b0001);
    idle(5);
    chk("op_count_saturated", 32'(op_count), 255);
    chk("scoreboard_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/nand_rr_scheduler.md
Name: nand_rr_scheduler

Overview:
Round-robin scheduler that shares one pipelined bitwise NAND execution unit among NUM_REQ requesters. It arbitrates requests, captures the winner's operands and tags each operation with the requester ID. It returns tagged results after a fixed latency and keeps a saturating completed-operation count. It sits between the project's input decode logic and the shared NAND datapath in the tt_um top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
W, 8, operand and result width in bits
LATENCY, 2, NAND unit pipeline depth in cycles (1..4)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
ena  in  1  design enable; when low no new grants are issued
req  in  NUM_REQ  per-requester request, level
op_a  in  NUM_REQ*W  packed operand A, requester i at bits [i*W +: W]
op_b  in  NUM_REQ*W  packed operand B, same packing
gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
rsp_valid  out  1  result valid pulse
rsp_id  out  3  ID of the requester that owns rsp_data
rsp_data  out  W  ~(a & b) for the granted operands
busy  out  1  any pipeline stage holds a valid op
op_count  out  8  completed operations, saturating

Behaviour:
- Reset (async, rst_n=0): rr pointer=0, all pipeline valid bits=0, rsp_valid=0, rsp_id=0, rsp_data=0, op_count=0, busy=0. gnt=0 while rst_n=0.
- Arbitration (combinational):
  - If ena=1 and req!=0, gnt is one-hot on the first index with req set, scanning ptr, ptr+1, ... mod NUM_REQ.
  - Otherwise gnt=0.
  - gnt is never set for a requester whose req=0.
- Transfer: an op is accepted at the rising edge where gnt[i]=1. op_a/op_b slice i and ID i are captured into stage 1, and ptr becomes (i+1) mod NUM_REQ. ptr is unchanged when nothing is granted.
- Requester protocol: hold req and operands stable until gnt is seen. Keeping req high after a grant requests another op. No gnt is needed to drop req.
- Pipeline: LATENCY stages with valid/id/data per stage; no stalls, no backpressure. An op accepted at edge T appears on rsp_valid/rsp_id/rsp_data during cycle T+LATENCY, registered. At most one op is accepted per cycle and at most one result is returned per cycle. Throughput is 1 op/cycle.
- rsp_data/rsp_id hold their last value when rsp_valid=0.
- busy = OR of stage valid bits. busy does not include the combinational gnt.
- ena low: gnt=0 immediately; ops already in flight still drain and complete, and op_count still increments.
- op_count: +1 on each cycle with rsp_valid=1; holds at 255.
- Fairness: with all req held high, grant order is 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 grants.
- Simultaneous events: a new accept and a result retiring in the same cycle are both handled. If reset asserts mid-flight, in-flight ops are discarded with no rsp_valid, and after release ptr restarts at 0.
- Width rules: rsp_id is zero-extended from clog2(NUM_REQ) bits. The NAND is bitwise over all W bits.

Test Plan:
- Single op: rst release, ena=1, req=0001, op_a[0]=0xF0, op_b[0]=0xCC -> gnt=0001 same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=0x3F; op_count=1; busy then 0.
- Fairness: req=1111 held for 8 cycles, op_a[i]=op_b[i]=i -> gnt sequence 1,2,4,8,1,2,4,8; responses with ids 0,1,2,3,0,1,2,3 and data 0xFF,0xFE,0xFD,0xFC, back-to-back with no bubbles.
- Pointer skip: after a grant to 1, req=0011 -> gnt=0001 (wrap past 2,3); next cycle req=0011 -> gnt=0010.
- ena gating: two ops in flight, then ena=0 with req=1111 -> gnt=0; both results still arrive; op_count=2; no further rsp_valid.
- Reset mid-flight: accept op, assert rst_n=0 one cycle later -> rsp_valid, busy, op_count all 0 immediately; no response after release; next grant with req=1111 goes to requester 0.
- Saturation: 260 ops via req=0001 held -> op_count reaches 255 and stays 255; rsp_valid keeps pulsing.
